// File: rtl/riscv_v_pkg.sv
// Shared types and constants for the vector writeback stage.
package riscv_v_pkg;

  localparam int unsigned RISCV_V_VLEN          = 128;
  localparam int unsigned RISCV_V_XLEN          = 32;
  localparam int unsigned RISCV_V_WB_BEAT_BYTES = 8;

  typedef struct packed {
    logic [RISCV_V_VLEN-1:0]   data;
    logic [RISCV_V_VLEN/8-1:0] byte_en;
    logic [4:0]                rd;
    logic                      is_v2i;
    logic [RISCV_V_XLEN-1:0]   int_data;
  } riscv_v_wb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } riscv_v_wb_state_e;

endpackage

// File: rtl/riscv_v_wb_beat_sel.sv
// Selects the VRF write beat (data slice + byte enables) for the current WB entry.
// With RISCV_V_WB_SKIP_EMPTY_EN defined, empty slices are skipped.
module riscv_v_wb_beat_sel
  import riscv_v_pkg::*;
#(
  parameter int unsigned VLEN       = RISCV_V_VLEN,
  parameter int unsigned BEAT_BYTES = RISCV_V_WB_BEAT_BYTES,
  parameter int unsigned BEATS      = VLEN / 8 / BEAT_BYTES,
  parameter int unsigned BW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic [VLEN-1:0]         data,
  input  logic [VLEN/8-1:0]       byte_en,
  input  logic [BW-1:0]           beat_q,
  output logic [BW-1:0]           cur_beat,
  output logic                    last_beat,
  output logic [BEAT_BYTES*8-1:0] beat_data,
  output logic [BEAT_BYTES-1:0]   beat_be
);

`ifdef RISCV_V_WB_SKIP_EMPTY_EN
  logic found;

  // byte_en only holds unwritten bytes, so the first non-empty slice at or
  // after beat_q is the next one to issue.
  always_comb begin
    cur_beat  = beat_q;
    found     = 1'b0;
    last_beat = 1'b1;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (!found && (b >= int'(beat_q)) && (|byte_en[b*BEAT_BYTES +: BEAT_BYTES])) begin
        cur_beat = BW'(b);
        found    = 1'b1;
      end
    end
    for (int unsigned b = 0; b < BEATS; b++) begin
      if ((b > int'(cur_beat)) && (|byte_en[b*BEAT_BYTES +: BEAT_BYTES])) begin
        last_beat = 1'b0;
      end
    end
  end
`else
  always_comb begin
    cur_beat  = beat_q;
    last_beat = (beat_q == BW'(BEATS - 1));
  end
`endif

  assign beat_data = data[cur_beat*BEAT_BYTES*8 +: BEAT_BYTES*8];
  assign beat_be   = byte_en[cur_beat*BEAT_BYTES +: BEAT_BYTES];

endmodule

// File: rtl/riscv_v_writeback.sv
// Vector writeback: MEM/WB pipeline registers, beat-wise VRF drain and v2i return.
// Optional RISCV_V_WB_SKIP_EMPTY_EN: skip beats with no enabled bytes.
module riscv_v_writeback
  import riscv_v_pkg::*;
#(
  parameter int unsigned VLEN       = RISCV_V_VLEN,
  parameter int unsigned XLEN       = RISCV_V_XLEN,
  parameter int unsigned BEAT_BYTES = RISCV_V_WB_BEAT_BYTES,
  localparam int unsigned BEATS     = VLEN / 8 / BEAT_BYTES,
  localparam int unsigned BW        = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int unsigned NB        = VLEN / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    exe_valid,
  output logic                    exe_ready,
  input  logic [VLEN-1:0]         exe_data,
  input  logic [NB-1:0]           exe_byte_en,
  input  logic [4:0]              exe_rd,
  input  logic                    exe_is_v2i,
  input  logic [XLEN-1:0]         exe_int_data,
  output logic [NB-1:0]           rf_wr_en_mem,
  output logic [4:0]              rf_wr_addr_mem,
  output logic [VLEN-1:0]         rf_wr_data_mem,
  output logic [NB-1:0]           rf_wr_en_wb,
  output logic [4:0]              rf_wr_addr_wb,
  output logic [VLEN-1:0]         rf_wr_data_wb,
  output logic                    vrf_wr_valid,
  input  logic                    vrf_wr_ready,
  output logic [4:0]              vrf_wr_addr,
  output logic [BW-1:0]           vrf_wr_beat,
  output logic [BEAT_BYTES*8-1:0] vrf_wr_data,
  output logic [BEAT_BYTES-1:0]   vrf_wr_be,
  output logic                    int_wr_valid,
  output logic [XLEN-1:0]         int_wr_data
);

  riscv_v_wb_state_e state_q, state_d;
  riscv_v_wb_entry_t mem_q, mem_d, wb_q, wb_d;
  logic              mem_valid_q, mem_valid_d;
  logic              wb_vrf_q, wb_vrf_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [BW-1:0]     cur_beat;
  logic              last_beat;
  logic              beat_acc, wb_done, mem_to_wb;
  logic [NB-1:0]     slice_mask;

  riscv_v_wb_beat_sel #(
    .VLEN       (VLEN),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_beat_sel (
    .data      (wb_q.data),
    .byte_en   (wb_q.byte_en),
    .beat_q    (beat_q),
    .cur_beat  (cur_beat),
    .last_beat (last_beat),
    .beat_data (vrf_wr_data),
    .beat_be   (vrf_wr_be)
  );

  assign vrf_wr_valid = (state_q == WRITE) && wb_vrf_q;
  assign beat_acc     = vrf_wr_valid && vrf_wr_ready;
  assign slice_mask   = NB'({BEAT_BYTES{1'b1}}) << (cur_beat * BEAT_BYTES);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wb_d        = wb_q;
    wb_vrf_d    = wb_vrf_q;
    mem_d       = mem_q;
    mem_valid_d = mem_valid_q;
    wb_done     = 1'b0;

    // wb_done means WB frees up this cycle (idle, v2i/empty entry, or last beat).
    case (state_q)
      IDLE: wb_done = 1'b1;
      WRITE: begin
        if (!wb_vrf_q) begin
          wb_done = 1'b1;
        end else if (beat_acc) begin
          wb_d.byte_en = wb_q.byte_en & ~slice_mask;
          beat_d       = cur_beat + 1'b1;
          wb_done      = last_beat;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_to_wb = mem_valid_q && wb_done;
    exe_ready = !mem_valid_q || mem_to_wb;

    if (wb_done) begin
      beat_d = '0;
      if (mem_to_wb) begin
        state_d  = WRITE;
        wb_d     = mem_q;
        wb_vrf_d = !mem_q.is_v2i && (|mem_q.byte_en);
      end else begin
        state_d  = IDLE;
      end
    end

    if (exe_valid && exe_ready) begin
      mem_valid_d    = 1'b1;
      mem_d.data     = exe_data;
      mem_d.byte_en  = exe_byte_en;
      mem_d.rd       = exe_rd;
      mem_d.is_v2i   = exe_is_v2i;
      mem_d.int_data = exe_int_data;
    end else if (mem_to_wb) begin
      mem_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      wb_q        <= '0;
      wb_vrf_q    <= 1'b0;
      mem_q       <= '0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wb_q        <= wb_d;
      wb_vrf_q    <= wb_vrf_d;
      mem_q       <= mem_d;
      mem_valid_q <= mem_valid_d;
    end
  end

  assign rf_wr_en_mem   = (mem_valid_q && !mem_q.is_v2i) ? mem_q.byte_en : '0;
  assign rf_wr_addr_mem = mem_q.rd;
  assign rf_wr_data_mem = mem_q.data;
  assign rf_wr_en_wb    = ((state_q == WRITE) && !wb_q.is_v2i) ? wb_q.byte_en : '0;
  assign rf_wr_addr_wb  = wb_q.rd;
  assign rf_wr_data_wb  = wb_q.data;
  assign vrf_wr_addr    = wb_q.rd;
  assign vrf_wr_beat    = cur_beat;
  assign int_wr_valid   = (state_q == WRITE) && wb_q.is_v2i;
  assign int_wr_data    = wb_q.int_data;

endmodule

// File: tb/tb_riscv_v_writeback.sv
// Self-checking bench for riscv_v_writeback: directed cases plus randomized traffic
// checked by a scoreboard against a byte-level VRF reference model.
module tb_riscv_v_writeback;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         exe_valid = 1'b0;
  logic         exe_ready;
  logic [127:0] exe_data = '0;
  logic [15:0]  exe_byte_en = '0;
  logic [4:0]   exe_rd = '0;
  logic         exe_is_v2i = 1'b0;
  logic [31:0]  exe_int_data = '0;
  logic [15:0]  rf_wr_en_mem;
  logic [4:0]   rf_wr_addr_mem;
  logic [127:0] rf_wr_data_mem;
  logic [15:0]  rf_wr_en_wb;
  logic [4:0]   rf_wr_addr_wb;
  logic [127:0] rf_wr_data_wb;
  logic         vrf_wr_valid;
  logic         vrf_wr_ready = 1'b0;
  logic [4:0]   vrf_wr_addr;
  logic [0:0]   vrf_wr_beat;
  logic [63:0]  vrf_wr_data;
  logic [7:0]   vrf_wr_be;
  logic         int_wr_valid;
  logic [31:0]  int_wr_data;

  riscv_v_writeback dut (
    .clk            (clk),
    .rst            (rst),
    .exe_valid      (exe_valid),
    .exe_ready      (exe_ready),
    .exe_data       (exe_data),
    .exe_byte_en    (exe_byte_en),
    .exe_rd         (exe_rd),
    .exe_is_v2i     (exe_is_v2i),
    .exe_int_data   (exe_int_data),
    .rf_wr_en_mem   (rf_wr_en_mem),
    .rf_wr_addr_mem (rf_wr_addr_mem),
    .rf_wr_data_mem (rf_wr_data_mem),
    .rf_wr_en_wb    (rf_wr_en_wb),
    .rf_wr_addr_wb  (rf_wr_addr_wb),
    .rf_wr_data_wb  (rf_wr_data_wb),
    .vrf_wr_valid   (vrf_wr_valid),
    .vrf_wr_ready   (vrf_wr_ready),
    .vrf_wr_addr    (vrf_wr_addr),
    .vrf_wr_beat    (vrf_wr_beat),
    .vrf_wr_data    (vrf_wr_data),
    .vrf_wr_be      (vrf_wr_be),
    .int_wr_valid   (int_wr_valid),
    .int_wr_data    (int_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic        beat;
    logic [63:0] data;
    logic [7:0]  be;
  } beat_t;

  beat_t        exp_q[$];
  logic [31:0]  int_q[$];
  logic [127:0] ref_vrf [32];
  logic [127:0] dut_vrf [32];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic         rand_ready = 1'b0;
  logic         ready_val  = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout, expected handshake within cycle budget", name);
  endtask

  task automatic clear_model();
    exp_q.delete();
    int_q.delete();
    for (int r = 0; r < 32; r++) begin
      ref_vrf[r] = '0;
      dut_vrf[r] = '0;
    end
  endtask

  // Reference: an accepted entry becomes a list of expected VRF beats (or one scalar),
  // and its enabled bytes land in the reference register image.
  task automatic model_push(input logic [4:0] rd, input logic [127:0] data,
                            input logic [15:0] be, input logic v2i, input logic [31:0] idata);
    logic [7:0] sl;
    if (v2i) begin
      int_q.push_back(idata);
    end else if (be != 16'h0) begin
      for (int b = 0; b < 2; b++) begin
        sl = be[b*8 +: 8];
`ifdef RISCV_V_WB_SKIP_EMPTY_EN
        if (sl == 8'h00) continue;
`endif
        exp_q.push_back('{rd: rd, beat: 1'(b), data: data[b*64 +: 64], be: sl});
      end
      for (int j = 0; j < 16; j++)
        if (be[j]) ref_vrf[rd][j*8 +: 8] = data[j*8 +: 8];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Must be called just after a rising edge; returns just after the transfer edge.
  task automatic send(input logic [4:0] rd, input logic [127:0] data,
                      input logic [15:0] be, input logic v2i, input logic [31:0] idata);
    bit ok = 1'b0;
    exe_valid = 1'b1; exe_rd = rd; exe_data = data; exe_byte_en = be;
    exe_is_v2i = v2i; exe_int_data = idata;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (exe_ready) ok = 1'b1;
      else step();
    end
    if (!ok) begin
      timeout_fail("exe_ready_wait");
      exe_valid = 1'b0;
      step();
      return;
    end
    @(posedge clk);
    model_push(rd, data, be, v2i, idata);
    #1;
    exe_valid = 1'b0;
  endtask

  always begin
    @(posedge clk);
    #1;
    vrf_wr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_val;
  end

  // Monitor: pops expected beats/scalars as the DUT presents them.
  beat_t       mon_e;
  logic [31:0] mon_i;
  logic [77:0] prev_tuple;
  logic        prev_pend = 1'b0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (prev_pend)
        check("vrf_hold_stable", {vrf_wr_valid, vrf_wr_addr, vrf_wr_beat, vrf_wr_data, vrf_wr_be},
              {1'b1, prev_tuple});
      if (vrf_wr_valid && vrf_wr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL vrf_unexpected_beat: got addr %0d beat %0d, expected no beat",
                   vrf_wr_addr, vrf_wr_beat);
        end else begin
          mon_e = exp_q.pop_front();
          check("vrf_beat", {vrf_wr_addr, vrf_wr_beat, vrf_wr_data, vrf_wr_be}, mon_e);
        end
        for (int j = 0; j < 8; j++)
          if (vrf_wr_be[j]) dut_vrf[vrf_wr_addr][(int'(vrf_wr_beat)*8 + j)*8 +: 8] = vrf_wr_data[j*8 +: 8];
      end
      if (int_wr_valid) begin
        if (int_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL int_unexpected: got %h, expected no scalar", int_wr_data);
        end else begin
          mon_i = int_q.pop_front();
          check("int_wr_data", int_wr_data, mon_i);
        end
      end
      prev_pend  = vrf_wr_valid && !vrf_wr_ready;
      prev_tuple = {vrf_wr_addr, vrf_wr_beat, vrf_wr_data, vrf_wr_be};
    end else begin
      prev_pend = 1'b0;
    end
  end

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 2000 && (exp_q.size() != 0 || int_q.size() != 0); i++) @(negedge clk);
    if (exp_q.size() != 0 || int_q.size() != 0) timeout_fail(name);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got time limit, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d_a, d_b;
    logic [15:0]  be;
    int           sel;
    clear_model();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {vrf_wr_valid, rf_wr_en_mem, rf_wr_en_wb, int_wr_valid, vrf_wr_beat,
                            vrf_wr_be, vrf_wr_data}, '0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {exe_ready, vrf_wr_valid}, 2'b10);

    // Single full entry, idle pipe
    step();
    send(5'd3, 128'h0f0e0d0c0b0a09080706050403020100, 16'hFFFF, 1'b0, 32'h0);
    @(negedge clk);
    check("t1_mem", {rf_wr_en_mem, rf_wr_addr_mem, vrf_wr_valid}, {16'hFFFF, 5'd3, 1'b0});
    @(negedge clk);
    check("t1_beat0", {vrf_wr_valid, vrf_wr_addr, vrf_wr_beat, vrf_wr_be, rf_wr_en_wb},
          {1'b1, 5'd3, 1'b0, 8'hFF, 16'hFFFF});
    check("t1_beat0_data", vrf_wr_data, 64'h0706050403020100);
    @(negedge clk);
    check("t1_beat1", {vrf_wr_valid, vrf_wr_addr, vrf_wr_beat, vrf_wr_be, rf_wr_en_wb},
          {1'b1, 5'd3, 1'b1, 8'hFF, 16'hFF00});
    @(negedge clk);
    check("t1_done", {vrf_wr_valid, rf_wr_en_wb}, '0);

    // Back-to-back entries with VRF stalled
    ready_val = 1'b0;
    step();
    d_a = {4{32'hA5A5_0001}};
    d_b = {4{32'h5A5A_0002}};
    send(5'd5, d_a, 16'hFFFF, 1'b0, 32'h0);
    send(5'd6, d_b, 16'hFFFF, 1'b0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t2_stall_ctrl", {exe_ready, vrf_wr_valid, rf_wr_addr_wb, rf_wr_addr_mem, rf_wr_en_wb,
                              rf_wr_en_mem}, {1'b0, 1'b1, 5'd5, 5'd6, 16'hFFFF, 16'hFFFF});
      check("t2_stall_data", {rf_wr_data_wb ^ d_a, rf_wr_data_mem ^ d_b}, '0);
    end
    ready_val = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t2_no_bubble", {vrf_wr_valid, vrf_wr_ready, vrf_wr_addr, vrf_wr_beat},
            {2'b11, (c < 2) ? 5'd5 : 5'd6, 1'(c)});
    end
    drain("t2_drain");

    // Half-empty entry
    step();
    send(5'd7, {4{32'h1234_5678}}, 16'h00FF, 1'b0, 32'h0);
    @(negedge clk);
    check("t3_mem_en", rf_wr_en_mem, 16'h00FF);
    @(negedge clk);
    check("t3_beat0", {vrf_wr_valid, vrf_wr_beat, vrf_wr_be}, {1'b1, 1'b0, 8'hFF});
    @(negedge clk);
`ifdef RISCV_V_WB_SKIP_EMPTY_EN
    check("t3_skip_beat1", vrf_wr_valid, 1'b0);
`else
    check("t3_empty_beat1", {vrf_wr_valid, vrf_wr_beat, vrf_wr_be}, {1'b1, 1'b1, 8'h00});
`endif
    drain("t3_drain");

    // v2i entry
    step();
    send(5'd9, {4{32'hCAFE_F00D}}, 16'hFFFF, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    check("t4_mem_en_zero", rf_wr_en_mem, 16'h0);
    @(negedge clk);
    check("t4_pulse", {int_wr_valid, int_wr_data, vrf_wr_valid, rf_wr_en_wb},
          {1'b1, 32'hDEADBEEF, 1'b0, 16'h0});
    @(negedge clk);
    check("t4_pulse_end", {int_wr_valid, vrf_wr_valid}, 2'b00);
    drain("t4_drain");

    // Reset during beat 1
    step();
    send(5'd10, {4{32'h0BAD_0BAD}}, 16'hFFFF, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t5_async_reset", {vrf_wr_valid, rf_wr_en_mem, rf_wr_en_wb, int_wr_valid, vrf_wr_beat,
                             vrf_wr_be, vrf_wr_data}, '0);
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_no_replay", {vrf_wr_valid, rf_wr_en_wb}, '0);
    end
    step();
    send(5'd11, {4{32'h7777_1111}}, 16'hFFFF, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("t5_restart_beat0", {vrf_wr_valid, vrf_wr_addr, vrf_wr_beat}, {1'b1, 5'd11, 1'b0});
    drain("t5_drain");

    // Randomized traffic with random VRF backpressure
    clear_model();
    rand_ready = 1'b1;
    step();
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 2)) step();
      sel = $urandom_range(0, 5);
      case (sel)
        0: be = 16'hFFFF;
        1: be = 16'h00FF;
        2: be = 16'hFF00;
        3: be = 16'h0000;
        default: be = 16'($urandom);
      endcase
      send(5'($urandom_range(0, 31)), {$urandom, $urandom, $urandom, $urandom}, be,
           ($urandom_range(0, 7) == 0), $urandom);
    end
    drain("rand_drain");
    for (int r = 0; r < 32; r++)
      check($sformatf("vrf_image_r%0d", r), dut_vrf[r], ref_vrf[r]);
    check("queues_empty", {32'(exp_q.size()), 32'(int_q.size())}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
